// File: rtl/mod_dec_xor_if.sv
// Handshake bundle for the decryption AddRoundKey stage: input state/key side and result side.
// When MOD_DEC_XOR_BLKCNT_EN is defined the bundle also carries the completed-block counter.
interface mod_dec_xor_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         err;
`ifdef MOD_DEC_XOR_BLKCNT_EN
    logic [15:0]  blk_cnt;

    modport slave (
        input  in_valid, in_first, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last, err, blk_cnt
    );
    modport master (
        output in_valid, in_first, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last, err, blk_cnt
    );
`else
    modport slave (
        input  in_valid, in_first, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last, err
    );
    modport master (
        output in_valid, in_first, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last, err
    );
`endif
endinterface

// File: rtl/mod_dec_xor.sv
// AES-256 inverse-cipher AddRoundKey stage: key XOR, then InvMixColumns on rounds 1..NR-1, 2-stage pipeline.
// Optional completed-block counter output enabled by defining MOD_DEC_XOR_BLKCNT_EN.
module mod_dec_xor #(
    parameter int NR = 14
) (
    input  logic          clk,
    input  logic          rst,
    mod_dec_xor_if.slave  bus
);

    localparam logic [3:0] RND_MAX = 4'(NR);

    // Handshake: a beat moves when valid && ready on that side. Stage 1 may accept
    // whenever it is empty or is handing its beat to stage 2 in the same cycle;
    // in_ready depends only on register state and out_ready, never on in_valid.
    logic         s1_valid_q, s1_valid_d;
    logic [127:0] s1_state_q, s1_state_d;
    logic [3:0]   s1_round_q, s1_round_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         s2_valid_q, s2_valid_d;
    logic [127:0] out_state_q, out_state_d;
    logic [3:0]   out_round_q, out_round_d;
    logic         out_last_q, out_last_d;

    logic         s1_advance;
    logic         in_xfer;
    logic         s2_load;
    logic         mid_round;
    logic [3:0]   next_round;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    assign s1_advance = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s1_advance;
    assign in_xfer    = bus.in_valid && bus.in_ready;
    assign s2_load    = s1_valid_q && s1_advance;
    assign mid_round  = (s1_round_q >= 4'd1) && (s1_round_q <= RND_MAX - 4'd1);

    // Continuing past round 0 is an error; the counter parks at 0 until the next in_first.
    assign next_round = bus.in_first ? RND_MAX :
                        (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_state_d  = s1_state_q;
        s1_round_d  = s1_round_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        s2_valid_d  = s2_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_state_d = bus.in_state ^ bus.in_key;
            s1_round_d = next_round;
            cnt_d      = next_round;
            if (bus.in_first) begin
                err_d = 1'b0;
            end else if (cnt_q == 4'd0) begin
                err_d = 1'b1;
            end
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d  = 1'b1;
            out_state_d = mid_round ? inv_mix(s1_state_q) : s1_state_q;
            out_round_d = s1_round_q;
            out_last_d  = (s1_round_q == 4'd0);
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_state_q  <= '0;
            s1_round_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_state_q  <= s1_state_d;
            s1_round_q  <= s1_round_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            s2_valid_q  <= s2_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;

`ifdef MOD_DEC_XOR_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (s2_valid_q && bus.out_ready && out_last_q) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_mod_dec_xor.sv
// Directed bench for mod_dec_xor: hand-computed vectors plus a scoreboard fed by a GF(2^8) reference model.
module tb_mod_dec_xor;

  localparam int NR = 14;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mod_dec_xor_if bus ();

  mod_dec_xor #(.NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard: {state, round, last}
  logic [132:0] exp_q[$];
  logic [3:0]   m_cnt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a [4];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = gf_mul(8'h0e, a[r]) ^ gf_mul(8'h0b, a[(r+1)%4]) ^
                                  gf_mul(8'h0d, a[(r+2)%4]) ^ gf_mul(8'h09, a[(r+3)%4]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [127:0] k,
                                           input logic [3:0] rnd);
    if (rnd >= 4'd1 && rnd <= 4'(NR - 1)) return ref_inv_mix(s ^ k);
    return s ^ k;
  endfunction

  task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // monitor: pop on output transfers, push model results on input transfers
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt <= 4'd0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_queue_nonempty", 133'(exp_q.size() != 0), 133'd1);
        if (exp_q.size() != 0)
          chk("sb_item", {bus.out_state, bus.out_round, bus.out_last}, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [3:0] r;
        r = bus.in_first ? 4'(NR) : ((m_cnt == 4'd0) ? 4'd0 : m_cnt - 4'd1);
        m_cnt <= r;
        exp_q.push_back({ref_out(bus.in_state, bus.in_key, r), r, (r == 4'd0)});
      end
    end
  end

  // driver tasks
  task automatic drive(input logic first, input logic [127:0] st, input logic [127:0] key);
    int n;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_state = st;
    bus.in_key   = key;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("in_ready_timeout", 133'(bus.in_ready), 133'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_block(input int n, input logic start_first);
    for (int i = 0; i < n; i++) drive(start_first && (i == 0), rnd128(), rnd128());
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step_cycles(1);
      n++;
    end
    if (n == 100) chk("drain_timeout", 133'(exp_q.size()), 133'd0);
    step_cycles(2);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step_cycles(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [127:0] bp_s [4];
    logic [127:0] bp_k [4];
    int outs, ins, idx, acc, n;
    logic took;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    step_cycles(3);

    // reset state
    chk("rst_out_valid", 133'(bus.out_valid), 133'd0);
    chk("rst_out_state", 133'(bus.out_state), 133'd0);
    chk("rst_out_round", 133'(bus.out_round), 133'd0);
    chk("rst_out_last",  133'(bus.out_last),  133'd0);
    chk("rst_err",       133'(bus.err),       133'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready",  133'(bus.in_ready),  133'd1);

    // first round: key XOR only, 2-cycle latency
    drive(1'b1, 128'h0, 128'h000102030405060708090a0b0c0d0e0f);
    chk("lat_not_yet", 133'(bus.out_valid), 133'd0);
    step_cycles(1);
    chk("r14_valid", 133'(bus.out_valid), 133'd1);
    chk("r14_state", 133'(bus.out_state), 133'(128'h000102030405060708090a0b0c0d0e0f));
    chk("r14_round", 133'(bus.out_round), 133'd14);
    chk("r14_last",  133'(bus.out_last),  133'd0);

    // middle round InvMixColumns
    drive(1'b1, 128'h0, 128'h0);
    drive(1'b0, {4{32'h8e4da1bc}}, 128'h0);
    step_cycles(1);
    chk("mix_state", 133'(bus.out_state), 133'({4{32'hdb135345}}));
    chk("mix_round", 133'(bus.out_round), 133'd13);
    drain();

    // full block back to back
    outs = 0;
    ins  = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 15) begin
        bus.in_valid = 1'b1;
        bus.in_first = (i == 0);
        bus.in_state = rnd128();
        bus.in_key   = rnd128();
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_valid) outs++;
      if (bus.in_valid && bus.in_ready) ins++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("full_in_count",  133'(ins),  133'd15);
    chk("full_out_count", 133'(outs), 133'd15);
    drain();

    // protocol error after round 0, then recovery
    drive(1'b0, rnd128(), rnd128());
    chk("err_set", 133'(bus.err), 133'd1);
    drive(1'b0, rnd128(), rnd128());
    chk("err_sticky", 133'(bus.err), 133'd1);
    drive(1'b1, rnd128(), rnd128());
    chk("err_clear", 133'(bus.err), 133'd0);
    step_cycles(1);
    chk("recover_round", 133'(bus.out_round), 133'd14);
    drain();

    // backpressure with a continuous input stream (restarts a block mid-block)
    drive(1'b1, rnd128(), rnd128());
    drive(1'b0, rnd128(), rnd128());
    drain();
    for (int i = 0; i < 4; i++) begin
      bp_s[i] = rnd128();
      bp_k[i] = rnd128();
    end
    bus.out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_first = (idx == 0);
      bus.in_state = bp_s[idx];
      bus.in_key   = bp_k[idx];
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) acc++;
      if (c >= 2) chk("bp_state_stable", 133'(bus.out_state), 133'(bp_s[0] ^ bp_k[0]));
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    chk("bp_buffered",  133'(acc),           133'd2);
    chk("bp_in_ready",  133'(bus.in_ready),  133'd0);
    chk("bp_out_valid", 133'(bus.out_valid), 133'd1);
    bus.out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      bus.in_valid = 1'b1;
      bus.in_first = (idx == 0);
      bus.in_state = bp_s[idx];
      bus.in_key   = bp_k[idx];
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_sent", 133'(idx), 133'd4);
    drain();
    chk("bp_queue_empty", 133'(exp_q.size()), 133'd0);
    chk("bp_idle",        133'(bus.out_valid), 133'd0);

    // reset mid-block
    drive(1'b1, rnd128(), rnd128());
    drive(1'b0, rnd128(), rnd128());
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 133'(bus.out_valid), 133'd0);
    chk("midrst_in_ready",  133'(bus.in_ready),  133'd1);
    step_cycles(1);
    rst = 1'b1;
    drive(1'b0, rnd128(), rnd128());
    chk("midrst_cnt_zero_err", 133'(bus.err), 133'd1);
    step_cycles(1);
    chk("midrst_round0", 133'(bus.out_round), 133'd0);
    drive(1'b1, rnd128(), rnd128());
    drain();

`ifdef MOD_DEC_XOR_BLKCNT_EN
    pulse_reset();
    chk("blk_cnt_reset", 133'(bus.blk_cnt), 133'd0);
    for (int b = 0; b < 3; b++) send_block(15, 1'b1);
    drain();
    chk("blk_cnt_three", 133'(bus.blk_cnt), 133'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
